// File: rtl/simmem_bank_timing_model.sv
// Multi-bank DRAM row-buffer timing model: costs each accepted request from the per-bank
// open-row state and bank occupancy, and returns the service delay as a registered response.
module simmem_bank_timing_model #(
  parameter int unsigned AddrW          = 19,
  parameter int unsigned RowBufLenW     = 10,
  parameter int unsigned NumBanksW      = 2,
  parameter int unsigned RowHitCost     = 4,
  parameter int unsigned PrechargeCost  = 2,
  parameter int unsigned ActivationCost = 1,
  parameter int unsigned MaxBurstLenW   = 2,
  parameter int unsigned DelayW         = 6,
  parameter int unsigned IidW           = 3,
  parameter bit          OpenPage       = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [IidW-1:0]   req_iid_i,
  input  logic [AddrW-1:0]  req_addr_i,
  input  logic [7:0]        req_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IidW-1:0]   rsp_iid_o,
  output logic [DelayW-1:0] rsp_delay_o,
  output logic              rsp_hit_o,
  input  logic              flush_i
);

  localparam int unsigned NumBanks    = 1 << NumBanksW;
  localparam int unsigned RowW        = AddrW - RowBufLenW - NumBanksW;
  localparam int unsigned DelayMaxInt = (1 << DelayW) - 1;
  localparam int unsigned CostClosed  = ActivationCost + RowHitCost;
  localparam int unsigned CostHit     = RowHitCost;
  localparam int unsigned CostMiss    = PrechargeCost + ActivationCost + RowHitCost;

  typedef enum logic {StClosed, StOpen} bank_state_e;

  bank_state_e       state_q [NumBanks];
  bank_state_e       state_d [NumBanks];
  logic [RowW-1:0]   row_q   [NumBanks];
  logic [RowW-1:0]   row_d   [NumBanks];
  logic [DelayW-1:0] busy_q  [NumBanks];
  logic [DelayW-1:0] busy_d  [NumBanks];

  logic              rsp_valid_q, rsp_valid_d;
  logic [IidW-1:0]   rsp_iid_q, rsp_iid_d;
  logic [DelayW-1:0] rsp_delay_q, rsp_delay_d;
  logic              rsp_hit_q, rsp_hit_d;

  logic [NumBanksW-1:0] bank;
  logic [RowW-1:0]      row;
  logic [7:0]           len_clamp;
  logic [DelayW-1:0]    access;
  logic [DelayW-1:0]    beats_m1;
  logic [DelayW-1:0]    delay;
  logic                 hit;
  logic                 accept;

  function automatic logic [DelayW-1:0] sat_const(input int unsigned v);
    return (v > DelayMaxInt) ? '1 : DelayW'(v);
  endfunction

  function automatic logic [DelayW-1:0] sat_add(input logic [DelayW-1:0] a,
                                                input logic [DelayW-1:0] b);
    logic [DelayW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DelayW] ? '1 : s[DelayW-1:0];
  endfunction

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Cost the incoming request against the current (pre-update) bank state.
  always_comb begin
    bank      = req_addr_i[RowBufLenW +: NumBanksW];
    row       = req_addr_i[AddrW-1 -: RowW];
    len_clamp = (req_len_i > 8'(MaxBurstLenW)) ? 8'(MaxBurstLenW) : req_len_i;
    beats_m1  = sat_const((32'd1 << len_clamp) - 32'd1);
    hit       = 1'b0;
    access    = sat_const(CostClosed);
    if (state_q[bank] == StOpen) begin
      if (row_q[bank] == row) begin
        hit    = 1'b1;
        access = sat_const(CostHit);
      end else begin
        access = sat_const(CostMiss);
      end
    end
    delay = sat_add(sat_add(busy_q[bank], access), beats_m1);
  end

  always_comb begin
    for (int i = 0; i < NumBanks; i++) begin
      state_d[i] = state_q[i];
      row_d[i]   = row_q[i];
      busy_d[i]  = (busy_q[i] != '0) ? busy_q[i] - 1'b1 : busy_q[i];
      if (accept && (bank == NumBanksW'(i))) begin
        busy_d[i] = delay;
        if (OpenPage) begin
          state_d[i] = StOpen;
          row_d[i]   = row;
        end else begin
          state_d[i] = StClosed;
        end
      end
      // Flush closes rows but leaves occupancy untouched.
      if (flush_i) begin
        state_d[i] = StClosed;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_iid_d   = rsp_iid_q;
    rsp_delay_d = rsp_delay_q;
    rsp_hit_d   = rsp_hit_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_iid_d   = req_iid_i;
      rsp_delay_d = delay;
      rsp_hit_d   = hit;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBanks; i++) begin
        state_q[i] <= StClosed;
        row_q[i]   <= '0;
        busy_q[i]  <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_iid_q   <= '0;
      rsp_delay_q <= '0;
      rsp_hit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NumBanks; i++) begin
        state_q[i] <= state_d[i];
        row_q[i]   <= row_d[i];
        busy_q[i]  <= busy_d[i];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_iid_q   <= rsp_iid_d;
      rsp_delay_q <= rsp_delay_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_iid_o   = rsp_iid_q;
  assign rsp_delay_o = rsp_delay_q;
  assign rsp_hit_o   = rsp_hit_q;

endmodule
